product_accumulator: RTL
========================

# product_accumulator

Sequential accumulate stage directly downstream of the 4x4 array multiplier. Accepts one unsigned product per cycle over a valid/ready handshake, sums a programmable-length burst of products into a wider accumulator, then presents the total on a registered valid/ready output. Overflow either wraps or saturates, depending on a compile-time switch.

## Interface
- PROD_W, 8: product width; matches the multiplier output.
- ACC_W, 16: accumulator and sum width; must be ≥ PROD_W.
- CNT_W, 4: burst-length field width.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous abort; returns the block to IDLE and zeroes the accumulator.
- len  in  CNT_W  number of products in the burst; sampled only on the first accept of a burst.
- pValid  in  1  product valid.
- pData  in  PROD_W  unsigned product.
- pReady  out  1  block can accept a product.
- sum  out  ACC_W  burst total.
- sValid  out  1  sum valid.
- sReady  in  1  downstream accepts the sum.
- ovf  out  1  overflow occurred during this burst; valid while sValid is high.
- busy  out  1  high in ACC or DONE.

## Operation
- A transfer occurs when valid and ready are both high on a clock edge.
- The FSM has three states: IDLE, ACC and DONE.
- **IDLE**
  - pReady=1, sValid=0.
  - On a product accept: acc←pData, ovf←0, rem←len−1.
  - If len is 0 or 1, go to DONE. Otherwise go to ACC.
- **ACC**
  - pReady=1.
  - On a product accept: acc←acc+pData, rem←rem−1.
  - If rem was 1, go to DONE.
  - No accept means the state holds.
- **DONE**
  - pReady=0, sValid=1, sum=acc.
  - On sReady, go to IDLE. acc is retained until the next burst loads it.
- **clr**
  - Overrides everything in any state: next state is IDLE, and acc, rem and ovf are all cleared.
  - A product presented in the same cycle as clr is not accepted (pReady is forced to 0 that cycle).
- **Arithmetic**
  - pData is zero-extended to ACC_W.
  - Without SAT: wrap modulo 2^ACC_W; ovf sets sticky on any carry out of bit ACC_W−1.
  - len=0 is treated as len=1.
- pData is not examined when pValid=0.

## Timing
- Reset values: state=IDLE, acc=0, rem=0, ovf=0, sum=0, sValid=0, pReady=1, busy=0.
- pReady, sValid and busy decode directly from the state register. pReady additionally depends combinationally on clr. There is no other combinational path from input to output.
- Latency: sValid rises on the edge that accepts the last product, so it is visible the cycle after that accept.
- Throughput: one product per cycle within a burst. Each burst costs at least one extra DONE cycle, so the minimum spacing is len+1 cycles per burst.
- Backpressure: sValid and sum hold stable in DONE until sReady is seen. sReady outside DONE is ignored.
- Reset asserted mid-burst clears immediately and asynchronously; any partial sum is lost.

## Configuration
- **PRODUCT_ACC_SAT_EN defined:** an add that would exceed 2^ACC_W−1 clamps acc to all-ones and sets ovf. Further adds keep acc at all-ones.
- **Undefined:** wrap-around as described under Operation; ovf is still reported.

## Structure
- A shared package holds:
  - the state enum (ST_IDLE, ST_ACC, ST_DONE);
  - default width constants PROD_W_DEF=8, ACC_W_DEF=16, CNT_W_DEF=4.
- One natural sub-module: accum_add. It is purely combinational and holds the ACC_W adder, the carry-out and the optional saturation mux under the macro. The FSM, counter and registers live in the top.

## Test plan
- Reset, then a burst with len=3 and pData 5, 7, 9 on consecutive cycles, sReady=1: sValid is high one cycle after the third accept, sum=21, ovf=0, and pReady is back to 1 the following cycle.
- len=0 and len=1 with pData=0xE1: DONE is reached after one accept and sum=225.
- Overflow with ACC_W=16 and len=2, pData=0xFF each time, preloaded through a prior burst: use a separate config with ACC_W=9, pData 0xFF, 0xFF, 0xFF.
  - Without the macro: sum=0x0FD (765 mod 512), ovf=1.
  - With PRODUCT_ACC_SAT_EN: sum=0x1FF, ovf=1.
- Backpressure: hold sReady=0 for 4 cycles in DONE. sum stays stable, pReady=0, and a pValid presented during DONE is not accepted. Release sReady and the next burst then starts normally.
- Gapped input with len=4 and pValid toggling 1,0,1,0,1,1: sum is the total of the 4 accepted values only, and rem counts only accepts.
- clr asserted after 2 of 4 products, and separately rst_n pulsed mid-burst: both return to IDLE with acc=0, sValid=0, and no sum is emitted. A subsequent burst with len=2 and pData 3, 4 gives sum=7.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator slice.
package product_accumulator_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int CNT_W_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/product_accumulator_accum_add.sv
// Combinational accumulator adder with carry-out; PRODUCT_ACC_SAT_EN selects
// clamp-to-all-ones instead of wrap-around on overflow.
module accum_add
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  result,
    output logic              carry
);

    logic [ACC_W:0] full_s;

    // Widened add so the carry out of the top accumulator bit is visible
    always_comb begin
        full_s = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
        carry  = full_s[ACC_W];
`ifdef PRODUCT_ACC_SAT_EN
        result = carry ? {ACC_W{1'b1}} : full_s[ACC_W-1:0];
`else
        result = full_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Burst accumulator behind the array multiplier: sums len products, then holds
// the total on a valid/ready output. Overflow mode set by PRODUCT_ACC_SAT_EN.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [CNT_W-1:0]  len,
    input  logic              pValid,
    input  logic [PROD_W-1:0] pData,
    output logic              pReady,
    output logic [ACC_W-1:0]  sum,
    output logic              sValid,
    input  logic              sReady,
    output logic              ovf,
    output logic              busy
);

    state_e             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   rem_r;
    logic               ovf_r;

    logic [ACC_W-1:0]   addResult_s;
    logic               addCarry_s;
    logic               pAccept_s;
    logic [CNT_W-1:0]   firstRem_s;

    accum_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) uAdd (
        .acc    (acc_r),
        .addend (pData),
        .result (addResult_s),
        .carry  (addCarry_s)
    );

    assign pReady    = (state_r != ST_DONE) && !clr;
    assign pAccept_s = pValid && pReady;
    // len of zero behaves like a single-product burst
    assign firstRem_s = (len == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (len - CNT_W'(1));

    assign sum    = acc_r;
    assign ovf    = ovf_r;
    assign sValid = (state_r == ST_DONE);
    assign busy   = (state_r != ST_IDLE);

    // Burst FSM, remaining-count and accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            rem_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
        end else if (clr) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            rem_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pAccept_s) begin
                        acc_r   <= ACC_W'(pData);
                        ovf_r   <= 1'b0;
                        rem_r   <= firstRem_s;
                        state_r <= (len <= CNT_W'(1)) ? ST_DONE : ST_ACC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (pAccept_s) begin
                        acc_r   <= addResult_s;
                        ovf_r   <= ovf_r | addCarry_s;
                        rem_r   <= rem_r - CNT_W'(1);
                        state_r <= (rem_r == CNT_W'(1)) ? ST_DONE : ST_ACC;
                    end else begin
                        state_r <= ST_ACC;
                    end
                end
                ST_DONE: begin
                    // acc stays put so sum is stable under backpressure
                    if (sReady) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
